// File: rtl/tdm_demux_pkg.sv
// Shared definitions for the TDM demultiplexer and its future transmit-side counterpart.
//   tdm_state_e   : framing state (StHunt = unframed, StRecv = framed)
//   DefaultNumCh  : default number of channels per frame
//   DefaultSlotW  : default bits per channel slot
package tdm_demux_pkg;

   typedef enum logic {
      StHunt = 1'b0,
      StRecv = 1'b1
   } tdm_state_e;

   localparam int unsigned DefaultNumCh = 4;
   localparam int unsigned DefaultSlotW = 8;

endpackage

// File: rtl/sipo_shift.sv
// Serial-in parallel-out shift register, MSB first.
//   clk_in      : clock
//   rst_n_in    : asynchronous active-low reset, clears the register
//   shift_en_in : shift d_in into bit 0 this edge
//   clr_in      : clear the register; combined with shift_en_in the result is {0.., d_in}
//   d_in        : serial data
//   q_out       : register contents
module sipo_shift import tdm_demux_pkg::*; #(
   parameter int unsigned SLOT_W = DefaultSlotW
) (
   input  logic              clk_in,
   input  logic              rst_n_in,
   input  logic              shift_en_in,
   input  logic              clr_in,
   input  logic              d_in,
   output logic [SLOT_W-1:0] q_out
);

   logic [SLOT_W-1:0] q_q, q_d;

   always_comb begin
      q_d = q_q;
      if (clr_in) begin
         q_d = '0;
      end
      if (shift_en_in) begin
         q_d = {q_d[SLOT_W-2:0], d_in};
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q_out = q_q;

endmodule

// File: rtl/tdm_demux.sv
// TDM serial stream demultiplexer: recovers NUM_CH slots of SLOT_W bits from a framed
// serial stream into per-channel holding registers.
//   clk_in         : clock
//   rst_n_in       : asynchronous active-low reset
//   en_in          : bit strobe; inputs are sampled only when high
//   sdata_in       : serial data, MSB first, channel 0 first
//   fsync_in       : frame sync, marks the MSB of channel 0
//   data_out       : channel k at [k*SLOT_W +: SLOT_W], held until overwritten
//   valid_out      : one-cycle pulse on bit k when channel k updates
//   frame_done_out : one-cycle pulse when the last channel updates
//   sync_err_out   : one-cycle pulse on a missing or early frame sync
//   locked_out     : high while framed
module tdm_demux import tdm_demux_pkg::*; #(
   parameter int unsigned NUM_CH = DefaultNumCh,
   parameter int unsigned SLOT_W = DefaultSlotW
) (
   input  logic                     clk_in,
   input  logic                     rst_n_in,
   input  logic                     en_in,
   input  logic                     sdata_in,
   input  logic                     fsync_in,
   output logic [NUM_CH*SLOT_W-1:0] data_out,
   output logic [NUM_CH-1:0]        valid_out,
   output logic                     frame_done_out,
   output logic                     sync_err_out,
   output logic                     locked_out
);

   localparam int unsigned BitCntW = (SLOT_W > 1) ? $clog2(SLOT_W) : 1;
   localparam int unsigned ChCntW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [BitCntW-1:0] LastBit = BitCntW'(SLOT_W - 1);
   localparam logic [ChCntW-1:0]  LastCh  = ChCntW'(NUM_CH - 1);

   tdm_state_e                state_q, state_d;
   logic [BitCntW-1:0]        bit_cnt_q, bit_cnt_d;
   logic [ChCntW-1:0]         ch_cnt_q, ch_cnt_d;
   logic [NUM_CH*SLOT_W-1:0]  data_q, data_d;
   logic [NUM_CH-1:0]         valid_q, valid_d;
   logic                      frame_done_q, frame_done_d;
   logic                      sync_err_q, sync_err_d;
   logic                      shift_en, shift_clr;
   logic [SLOT_W-1:0]         sipo_q;
   logic [SLOT_W-1:0]         word;
   logic                      unused_sipo_msb;

   sipo_shift #(
      .SLOT_W (SLOT_W)
   ) u_sipo (
      .clk_in      (clk_in),
      .rst_n_in    (rst_n_in),
      .shift_en_in (shift_en),
      .clr_in      (shift_clr),
      .d_in        (sdata_in),
      .q_out       (sipo_q)
   );

   // The LSB is still on sdata_in when the word completes, so the stored word is taken
   // from the register's lower bits plus the live input; the register MSB is never needed.
   assign word            = {sipo_q[SLOT_W-2:0], sdata_in};
   assign unused_sipo_msb = sipo_q[SLOT_W-1];

   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      ch_cnt_d     = ch_cnt_q;
      data_d       = data_q;
      valid_d      = '0;
      frame_done_d = 1'b0;
      sync_err_d   = 1'b0;
      shift_en     = 1'b0;
      shift_clr    = 1'b0;

      if (en_in) begin
         unique case (state_q)
            StHunt: begin
               if (fsync_in) begin
                  shift_en  = 1'b1;
                  shift_clr = 1'b1;
                  bit_cnt_d = BitCntW'(1);
                  ch_cnt_d  = '0;
                  state_d   = StRecv;
               end
            end
            StRecv: begin
               if (bit_cnt_q == '0 && ch_cnt_q == '0 && !fsync_in) begin
                  // Sync missing at frame start: drop the bit and go re-hunt.
                  sync_err_d = 1'b1;
                  state_d    = StHunt;
               end else if (fsync_in) begin
                  // Sync anywhere restarts channel 0; only off frame start is it an error.
                  sync_err_d = (bit_cnt_q != '0) || (ch_cnt_q != '0);
                  shift_en   = 1'b1;
                  shift_clr  = 1'b1;
                  bit_cnt_d  = BitCntW'(1);
                  ch_cnt_d   = '0;
               end else begin
                  shift_en = 1'b1;
                  if (bit_cnt_q == LastBit) begin
                     bit_cnt_d = '0;
                     for (int unsigned k = 0; k < NUM_CH; k++) begin
                        if (ch_cnt_q == ChCntW'(k)) begin
                           data_d[k*SLOT_W +: SLOT_W] = word;
                           valid_d[k]                 = 1'b1;
                        end
                     end
                     frame_done_d = (ch_cnt_q == LastCh);
                     ch_cnt_d     = (ch_cnt_q == LastCh) ? '0 : ch_cnt_q + ChCntW'(1);
                  end else begin
                     bit_cnt_d = bit_cnt_q + BitCntW'(1);
                  end
               end
            end
            default: state_d = StHunt;
         endcase
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q      <= StHunt;
         bit_cnt_q    <= '0;
         ch_cnt_q     <= '0;
         data_q       <= '0;
         valid_q      <= '0;
         frame_done_q <= 1'b0;
         sync_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         ch_cnt_q     <= ch_cnt_d;
         data_q       <= data_d;
         valid_q      <= valid_d;
         frame_done_q <= frame_done_d;
         sync_err_q   <= sync_err_d;
      end
   end

   assign data_out       = data_q;
   assign valid_out      = valid_q;
   assign frame_done_out = frame_done_q;
   assign sync_err_out   = sync_err_q;
   assign locked_out     = (state_q == StRecv);

endmodule

// File: doc/tdm_demux.md
TDM_DEMUX -- requirements
Module: tdm_demux

Interface
REQ-001 Parameter NUM_CH, default 4: number of time-division channels per frame, range 2..16.
REQ-002 Parameter SLOT_W, default 8: bits per channel slot, range 2..32.
REQ-003 clk_in  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n_in  input  1  reset, asynchronous assert, active-low.
REQ-005 en_in  input  1  bit-enable strobe; sdata_in and fsync_in are sampled only on edges where en_in=1.
REQ-006 sdata_in  input  1  serial TDM stream, MSB first within each slot, channel 0 first within each frame.
REQ-007 fsync_in  input  1  frame sync, high during the enabled cycle that carries the MSB of channel 0.
REQ-008 data_out  output  NUM_CH*SLOT_W  per-channel holding registers; channel k occupies bits [k*SLOT_W +: SLOT_W].
REQ-009 valid_out  output  NUM_CH  one-cycle pulse on bit k when channel k register updates.
REQ-010 frame_done_out  output  1  one-cycle pulse when channel NUM_CH-1 updates.
REQ-011 sync_err_out  output  1  one-cycle pulse on any framing violation.
REQ-012 locked_out  output  1  high while in state RECV.

Function
REQ-013 The FSM SHALL have two states: HUNT (unframed) and RECV (framed), with bit counter bit_cnt (0..SLOT_W-1) and channel counter ch_cnt (0..NUM_CH-1).
REQ-014 On edges where en_in=0, the block SHALL hold all state; valid_out, frame_done_out and sync_err_out SHALL be 0 on the following cycle.
REQ-015 HUNT: sdata_in is ignored until an enabled edge with fsync_in=1; that bit SHALL be shifted in as the MSB of channel 0, with bit_cnt=1, ch_cnt=0 and state RECV.
REQ-016 RECV: each enabled edge SHALL shift sdata_in into the SIPO register and increment bit_cnt.
REQ-017 When the shifted bit is bit_cnt=SLOT_W-1, the assembled word SHALL be written to data_out channel ch_cnt and valid_out[ch_cnt] pulsed in the cycle after that edge (latency 1 cycle after the LSB is sampled); bit_cnt wraps to 0 and ch_cnt increments.
REQ-018 When ch_cnt=NUM_CH-1 completes, frame_done_out SHALL pulse in the same cycle as valid_out[NUM_CH-1], and ch_cnt SHALL wrap to 0.
REQ-019 RECV, enabled edge with bit_cnt=0, ch_cnt=0, fsync_in=1: normal frame start, no error.
REQ-020 RECV, enabled edge with bit_cnt=0, ch_cnt=0, fsync_in=0 (missing sync): sync_err_out SHALL pulse, the bit is discarded, and the state returns to HUNT.
REQ-021 RECV, enabled edge with fsync_in=1 at any other position (early sync): sync_err_out SHALL pulse, the partial word SHALL be discarded without a valid pulse, and the bit SHALL be taken as the MSB of channel 0 (bit_cnt=1, ch_cnt=0, stay in RECV).
REQ-022 data_out registers SHALL hold their last value until overwritten; channels are never cleared except by reset.
REQ-023 At most one valid_out bit SHALL be high in any cycle.

Reset
REQ-024 Asserting rst_n_in low SHALL immediately force state HUNT, bit_cnt=0, ch_cnt=0, shift register 0, data_out=0, valid_out=0, frame_done_out=0, sync_err_out=0, locked_out=0.
REQ-025 Reset asserted mid-slot SHALL discard the partial word with no valid pulse; after deassertion, reception SHALL require a fresh fsync_in.

Structure
REQ-026 State encodings (HUNT, RECV) and default NUM_CH/SLOT_W SHALL live in a shared include file used by tdm_demux and its future transmit-side counterpart.
REQ-027 The serial-to-parallel shifter SHALL be a separate sub-module sipo_shift (parameter SLOT_W; inputs clk_in, rst_n_in, shift_en_in, clr_in, d_in; output q_out).
REQ-028 Implementation size target: 120-400 lines of RTL.

Verification
REQ-029 Defaults, en_in=1, fsync on the first bit, frame bytes A5,3C,FF,01 -> valid_out pulses 0001,0010,0100,1000 at cycles 8,16,24,32 after the fsync edge; data_out=01FF3CA5; frame_done_out at cycle 32.
REQ-030 Same frame with en_in toggling 1,0 every cycle -> identical data_out and valid ordering, with each pulse at twice the cycle count.
REQ-031 Second frame sent without fsync_in -> sync_err_out pulses on its first bit, locked_out=0, data_out stays 01FF3CA5.
REQ-032 fsync_in reasserted at bit 3 of channel 2 -> sync_err_out pulse, no valid_out[2], next 8 bits 0x77 -> data_out channel 0=77.
REQ-033 rst_n_in low asynchronously during channel 1 -> all outputs 0 without a clock edge; with sdata_in toggling and no fsync after release -> locked_out stays 0 and no valid pulses.
REQ-034 NUM_CH=2, SLOT_W=4, two back-to-back frames 9,6 then 3,C -> data_out=69 then C3, frame_done_out twice, no sync_err_out.
